// File: rtl/vec_cache_rd_data_master_arb.sv
// ============================================================================
// Module  : vec_cache_rd_data_master_arb
// Brief   : Routes M cache-bank read-data sources to N per-master one-entry
//           output slots, with an independent round-robin arbiter per master.
//           Optional macro VEC_CACHE_RD_DATA_ARB_ERR_CHK_EN adds a sticky
//           illegal-master-id flag on err_id.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_cache_rd_data_pkg;
  // Master-id field is sized for the largest supported N (16 masters).
  localparam int c_MID_W = 4;
  localparam int c_TAG_W = 8;
  localparam int c_DAT_W = 32;

  typedef struct packed {
    logic [c_MID_W-1:0] master_id;
    logic [c_TAG_W-1:0] tag;
  } txn_id_t;

  typedef struct packed {
    txn_id_t            txn_id;
    logic [c_DAT_W-1:0] data;
  } us_data_pld_t;
endpackage

module vec_cache_rd_data_master_arb
  import vec_cache_rd_data_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [M-1:0]         in_vld,
  input  us_data_pld_t [M-1:0] in_pld,
  output logic [M-1:0]         in_rdy,
  output logic [N-1:0]         out_vld,
  output us_data_pld_t [N-1:0] out_pld,
  input  logic [N-1:0]         out_rdy,
  output logic                 err_id
);

  localparam int c_SRC_W = (M > 1) ? $clog2(M) : 1;

  logic [N-1:0][M-1:0] w_gnt_m;
  logic [M-1:0]        w_rdy;

  for (genvar j = 0; j < N; j++) begin : g_slot
    logic [M-1:0]       w_req;
    logic [M-1:0]       w_gnt;
    logic               w_hit;
    logic               w_take;
    logic [c_SRC_W-1:0] w_win;
    logic               r_vld;
    us_data_pld_t       r_pld;
    logic [c_SRC_W-1:0] r_rr;

    // Ids >= N can never equal any slot index, so illegal ids are never granted.
    always_comb begin
      w_req = '0;
      for (int i = 0; i < M; i++) begin
        w_req[i] = in_vld[i] && (int'(in_pld[i].txn_id.master_id) == j);
      end
    end

    always_comb begin
      logic [c_SRC_W-1:0] idx;
      idx   = '0;
      w_hit = 1'b0;
      w_win = '0;
      for (int k = 0; k < M; k++) begin
        idx = c_SRC_W'((int'(r_rr) + k) % M);
        if (!w_hit && w_req[idx]) begin
          w_hit = 1'b1;
          w_win = idx;
        end
      end
    end

    assign w_take     = w_hit && (!r_vld || out_rdy[j]);
    assign w_gnt      = w_take ? (M'(1) << w_win) : '0;
    assign w_gnt_m[j] = w_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_pld <= '0;
        r_rr  <= '0;
      end else if (w_take) begin
        r_vld <= 1'b1;
        r_pld <= in_pld[w_win];
        r_rr  <= (int'(w_win) == M - 1) ? '0 : w_win + 1'b1;
      end else if (out_rdy[j]) begin
        r_vld <= 1'b0;
      end
    end

    assign out_vld[j] = r_vld;
    assign out_pld[j] = r_pld;
  end

  // Each source targets one master, so at most one slot grants it.
  always_comb begin
    w_rdy = '0;
    for (int j = 0; j < N; j++) begin
      w_rdy = w_rdy | w_gnt_m[j];
    end
  end

  assign in_rdy = w_rdy & {M{rst_n}};

`ifdef VEC_CACHE_RD_DATA_ARB_ERR_CHK_EN
  logic w_bad_id;
  logic r_err_id;

  always_comb begin
    w_bad_id = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (in_vld[i] && (int'(in_pld[i].txn_id.master_id) >= N)) begin
        w_bad_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_id <= 1'b0;
    end else if (w_bad_id) begin
      r_err_id <= 1'b1;
    end
  end

  assign err_id = r_err_id;
`else
  assign err_id = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_cache_rd_data_master_arb.sv
// ============================================================================
// Module  : tb_vec_cache_rd_data_master_arb
// Brief   : Directed, table-driven bench for vec_cache_rd_data_master_arb.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_cache_rd_data_master_arb;
  import vec_cache_rd_data_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [7:0]          in_vld;
  us_data_pld_t [7:0]  in_pld;
  logic [7:0]          in_rdy;
  logic [15:0]         out_vld;
  us_data_pld_t [15:0] out_pld;
  logic [15:0]         out_rdy;
  logic                err_id;

  logic [7:0]          in_rdy2;
  logic [11:0]         out_vld2;
  us_data_pld_t [11:0] out_pld2;
  logic [11:0]         out_rdy2;
  logic                err_id2;

  int n_chk;
  int n_err;

  vec_cache_rd_data_master_arb #(.M(8), .N(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_pld  (in_pld),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_pld (out_pld),
    .out_rdy (out_rdy),
    .err_id  (err_id)
  );

  vec_cache_rd_data_master_arb #(.M(8), .N(12)) dut12 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_pld  (in_pld),
    .in_rdy  (in_rdy2),
    .out_vld (out_vld2),
    .out_pld (out_pld2),
    .out_rdy (out_rdy2),
    .err_id  (err_id2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [7:0]  vld;
    logic [31:0] mids;
    logic [7:0]  rdy;
    logic [15:0] ovld;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [3:0] mid, input logic [31:0] d);
    in_vld[i]                  = v;
    in_pld[i].txn_id.master_id = mid;
    in_pld[i].txn_id.tag       = 8'(i);
    in_pld[i].data             = d;
  endtask

  task automatic do_reset();
    in_vld  = '0;
    in_pld  = '0;
    out_rdy = '1;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    out_rdy2 = '1;
    in_vld   = 8'hFF;
    in_pld   = '0;
    out_rdy  = '1;
    rst_n    = 1'b0;

    tbl[0] = '{"distinct_0to7", 8'hFF, 32'h76543210, 8'hFF, 16'h00FF};
    tbl[1] = '{"src0_src3_m5",  8'h09, 32'h00005005, 8'h01, 16'h0020};
    tbl[2] = '{"all_to_m9",     8'hFF, 32'h99999999, 8'h01, 16'h0200};
    tbl[3] = '{"pairs_m15_m3",  8'hF0, 32'h33FF0000, 8'h50, 16'h8008};
    tbl[4] = '{"idle",          8'h00, 32'h00000000, 8'h00, 16'h0000};
    tbl[5] = '{"src1_src2_m12", 8'h06, 32'h00000CC0, 8'h02, 16'h1000};

    // Reset state with every source requesting
    #3;
    chk("rst_in_rdy", 32'(in_rdy), 32'h0);
    chk("rst_out_vld", 32'(out_vld), 32'h0);
    chk("rst_err_id", 32'(err_id), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_out_pld5", 32'(out_pld[5].data), 32'h0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        set_src(i, tbl[v].vld[i], tbl[v].mids[4*i +: 4], 32'h100 + 32'(i));
      end
      #1;
      chk({tbl[v].name, "_in_rdy"}, 32'(in_rdy), 32'(tbl[v].rdy));
      tick();
      chk({tbl[v].name, "_out_vld"}, 32'(out_vld), 32'(tbl[v].ovld));
    end

    // Two sources share master 5: back-to-back round-robin with 1-cycle latency
    do_reset();
    set_src(0, 1'b1, 4'd5, 32'hA0);
    set_src(3, 1'b1, 4'd5, 32'hA3);
    #1;
    chk("rr_c0_in_rdy", 32'(in_rdy), 32'h01);
    tick();
    in_vld[0] = 1'b0;
    #1;
    chk("rr_c1_in_rdy", 32'(in_rdy), 32'h08);
    chk("rr_c1_vld5", 32'(out_vld[5]), 32'h1);
    chk("rr_c1_pld5", out_pld[5].data, 32'hA0);
    tick();
    in_vld[3] = 1'b0;
    chk("rr_c2_vld5", 32'(out_vld[5]), 32'h1);
    chk("rr_c2_pld5", out_pld[5].data, 32'hA3);
    tick();
    chk("rr_c3_vld5", 32'(out_vld[5]), 32'h0);
    chk("rr_c3_pld5_hold", out_pld[5].data, 32'hA3);

    // Backpressure on master 2
    do_reset();
    out_rdy[2] = 1'b0;
    set_src(0, 1'b1, 4'd2, 32'hB0);
    #1;
    chk("bp_fill_in_rdy", 32'(in_rdy), 32'h01);
    tick();
    in_vld[0] = 1'b0;
    set_src(1, 1'b1, 4'd2, 32'hB1);
    #1;
    chk("bp_full_in_rdy", 32'(in_rdy), 32'h00);
    tick();
    chk("bp_full_in_rdy2", 32'(in_rdy), 32'h00);
    chk("bp_full_vld2", 32'(out_vld[2]), 32'h1);
    chk("bp_full_pld2", out_pld[2].data, 32'hB0);
    out_rdy[2] = 1'b1;
    #1;
    chk("bp_release_in_rdy", 32'(in_rdy), 32'h02);
    tick();
    in_vld[1] = 1'b0;
    chk("bp_new_vld2", 32'(out_vld[2]), 32'h1);
    chk("bp_new_pld2", out_pld[2].data, 32'hB1);
    tick();
    chk("bp_drain_vld2", 32'(out_vld[2]), 32'h0);

    // Three sources held to master 9: order 0,1,2,0,1,2
    do_reset();
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, 4'd9, 32'hC0 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr9_c%0d_in_rdy", c), 32'(in_rdy), 32'(8'h01 << (c % 3)));
      tick();
      chk($sformatf("rr9_c%0d_pld9", c), out_pld[9].data, 32'hC0 + 32'(c % 3));
    end

    // Asynchronous reset while master 5 holds data and rr[5]=2
    do_reset();
    out_rdy[5] = 1'b0;
    set_src(1, 1'b1, 4'd5, 32'hD1);
    #1;
    chk("ar_pre_in_rdy", 32'(in_rdy), 32'h02);
    tick();
    in_vld[1] = 1'b0;
    chk("ar_pre_vld5", 32'(out_vld[5]), 32'h1);
    #2;
    rst_n = 1'b0;
    set_src(1, 1'b1, 4'd5, 32'hD1);
    set_src(2, 1'b1, 4'd5, 32'hD2);
    #1;
    chk("ar_in_vld", 32'(out_vld), 32'h0);
    chk("ar_in_rdy", 32'(in_rdy), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("ar_post_in_rdy", 32'(in_rdy), 32'h02);
    tick();
    chk("ar_post_pld5", out_pld[5].data, 32'hD1);

    // Illegal master id on the N=12 instance
    do_reset();
    #1;
    chk("err_after_rst", 32'(err_id2), 32'h0);
    set_src(4, 1'b1, 4'd13, 32'hE4);
    #1;
    chk("err_c0_in_rdy4", 32'(in_rdy2[4]), 32'h0);
    chk("err_c0_err_id", 32'(err_id2), 32'h0);
    for (int c = 1; c < 4; c++) begin
      tick();
      if (c == 2) in_vld[4] = 1'b0;
      #1;
      chk($sformatf("err_c%0d_in_rdy4", c), 32'(in_rdy2[4]), 32'h0);
`ifdef VEC_CACHE_RD_DATA_ARB_ERR_CHK_EN
      chk($sformatf("err_c%0d_err_id", c), 32'(err_id2), 32'h1);
`else
      chk($sformatf("err_c%0d_err_id", c), 32'(err_id2), 32'h0);
`endif
    end
    chk("err_n16_err_id", 32'(err_id), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("err_rst_clear", 32'(err_id2), 32'h0);
    tick();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vec_cache_rd_data_master_arb.md
VEC_CACHE_RD_DATA_MASTER_ARB -- requirements
Module: vec_cache_rd_data_master_arb

Interface
REQ-001 Parameter M, default 8, number of read-data source channels (cache banks).
REQ-002 Parameter N, default 16, number of upstream masters; master index width is $clog2(N).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_vld  input  M  per-source payload valid.
REQ-006 in_pld  input  us_data_pld_t[M]  per-source payload; target master = in_pld[i].txn_id.master_id.
REQ-007 in_rdy  output  M  per-source accept; a transfer occurs when in_vld[i] and in_rdy[i] are both high.
REQ-008 out_vld  output  N  per-master registered valid.
REQ-009 out_pld  output  us_data_pld_t[N]  per-master registered payload.
REQ-010 out_rdy  input  N  per-master accept.
REQ-011 err_id  output  1  sticky illegal-master-id flag; tied 0 when the error-check feature is compiled out.

Function
REQ-012 Each master j SHALL own a one-entry output slot (out_vld[j], out_pld[j]).
REQ-013 Slot j is free in a cycle when out_vld[j]==0 or out_rdy[j]==1.
REQ-014 Requesters of slot j are all sources i with in_vld[i]==1 and master_id==j.
REQ-015 Each slot with a free condition and at least one requester grants exactly one requester, chosen by round-robin starting at pointer rr[j] (width $clog2(M)).
REQ-016 in_rdy[i] is high only when source i is granted; in_rdy is combinational from in_vld, in_pld, out_vld, out_rdy and rr.
REQ-017 On grant, out_pld[j] loads the winner's payload and out_vld[j] is 1 on the next edge; latency is 1 cycle input-to-output.
REQ-018 On out_vld[j]&&out_rdy[j] without a new grant, out_vld[j] clears on the next edge; out_pld[j] holds its value.
REQ-019 Throughput: one transfer per master per cycle when out_rdy[j] is held high.
REQ-020 rr[j] updates to (winner+1) mod M on grant only; it holds otherwise and wraps from M-1 to 0.
REQ-021 Non-granted sources see in_rdy low and must hold their payload; the block stores no inputs other than the slots.
REQ-022 Sources targeting different masters never block each other; all N slots arbitrate independently in the same cycle.
REQ-023 A source whose master_id >= N (possible when N is not a power of two) is never granted.

Reset
REQ-024 While rst_n is low: out_vld=0, out_pld=0, all rr[j]=0, err_id=0, in_rdy=0.
REQ-025 Reset assertion mid-transfer drops slot contents without an output handshake; the first grant after release starts from source 0.

Configuration
REQ-026 Macro VEC_CACHE_RD_DATA_ARB_ERR_CHK_EN.
REQ-027 When defined: err_id sets on the edge after any in_vld[i] with master_id >= N and stays set until reset; such a source is never granted per REQ-023.
REQ-028 When undefined: err_id is constant 0, no check logic is built, and REQ-023 still applies.

Verification
REQ-029 Sources 0 and 3 valid, both master 5, out_rdy=all 1, rr=0 -> cycle0 grants src0; cycle1 grants src3; out_vld[5] high 2 consecutive cycles with src0 then src3 payload.
REQ-030 All 8 sources valid, distinct masters 0..7 -> all in_rdy=8'hFF in one cycle; out_vld=16'h00FF next cycle.
REQ-031 Master 2 has out_rdy=0 with slot full, src1 valid to master 2 -> in_rdy[1]=0 and out_pld[2] stable; raise out_rdy[2] -> src1 accepted that cycle, new payload visible next cycle.
REQ-032 Sources 0,1,2 held valid to master 9 for 6 cycles -> grant order 0,1,2,0,1,2; rr[9] sequence 1,2,0,1,2,0.
REQ-033 N=12, macro defined, src4 valid with master_id=13 -> in_rdy[4]=0 forever, err_id=1 from next cycle until rst_n low.
REQ-034 rst_n driven low while out_vld[5]=1 and rr[5]=2 -> out_vld=0, rr[5]=0 immediately; after release, sources 1 and 2 to master 5 -> src1 is granted first.
